// File: rtl/core_pkg.sv
// Shared RV32I core definitions: widths, opcode/func7 constants and the
// decoded-entry record carried from decode into the ALU pipeline register.
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [XLEN-1:0]       operand_1;
        logic [XLEN-1:0]       operand_2;
        logic [2:0]            alu_op;
        logic [6:0]            alu_op2;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  illegal;
    } dec_t;

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{(XLEN-12){instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_u(input logic [31:0] instr);
        return {instr[31:12], 12'b0};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and ALU-side handshake bundle of the decode stage.
// master = environment (fetch + ALU), slave = decode_stage.
interface decode_stage_if;

    logic                     if_valid;
    logic                     if_ready;
    logic [31:0]              if_instr;
    logic [31:0]              if_pc;

    logic                     ex_valid;
    logic                     ex_ready;
    logic [core_pkg::XLEN-1:0] ex_operand_1;
    logic [core_pkg::XLEN-1:0] ex_operand_2;
    logic [2:0]               ex_alu_op;
    logic [6:0]               ex_alu_op2;
    logic [4:0]               ex_rd;
    logic                     ex_reg_write;
    logic                     ex_illegal;
    logic [31:0]              ex_pc;

    modport master (
        output if_valid, if_instr, if_pc, ex_ready,
        input  if_ready, ex_valid, ex_operand_1, ex_operand_2, ex_alu_op,
               ex_alu_op2, ex_rd, ex_reg_write, ex_illegal, ex_pc
    );

    modport slave (
        input  if_valid, if_instr, if_pc, ex_ready,
        output if_ready, ex_valid, ex_operand_1, ex_operand_2, ex_alu_op,
               ex_alu_op2, ex_rd, ex_reg_write, ex_illegal, ex_pc
    );

endinterface

// File: rtl/regfile.sv
// 32x32 register file, 2 async read ports, 1 write port, x0 reads zero.
// Optional same-cycle writeback bypass when DECODE_WB_BYPASS_EN is defined.
module regfile
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic [XLEN-1:0]       o_rs1_data,
    output logic [XLEN-1:0]       o_rs2_data,
    input  logic                  i_wb_en,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    input  logic [XLEN-1:0]       i_wb_data
);

    logic [XLEN-1:0] r_regs [REG_COUNT];

    // NOTE: the array is cleared in reset because architectural state must read
    // zero after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_rd != '0)) begin
            r_regs[i_wb_rd] <= i_wb_data;
        end
    end

    always_comb begin
        o_rs1_data = (i_rs1_addr == '0) ? '0 : r_regs[i_rs1_addr];
        o_rs2_data = (i_rs2_addr == '0) ? '0 : r_regs[i_rs2_addr];
`ifdef DECODE_WB_BYPASS_EN
        if (i_wb_en && (i_wb_rd != '0) && (i_wb_rd == i_rs1_addr)) o_rs1_data = i_wb_data;
        if (i_wb_en && (i_wb_rd != '0) && (i_wb_rd == i_rs2_addr)) o_rs2_data = i_wb_data;
`else
        // Without bypass the write lands at the edge; reads see it next cycle.
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: decodes R/I/LUI/AUIPC into a one-entry ALU pipeline register.
// Build option DECODE_WB_BYPASS_EN enables same-cycle writeback bypass in regfile.
module decode_stage
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    decode_stage_if.slave         bus,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data
);

    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;
    logic [6:0]      w_opcode;
    logic [2:0]      w_func3;
    logic [6:0]      w_func7;
    logic            w_capture;
    dec_t            w_dec;

    dec_t            r_ex;
    logic            r_valid;
    logic [31:0]     r_pc;

    regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .i_rs1_addr (bus.if_instr[19:15]),
        .i_rs2_addr (bus.if_instr[24:20]),
        .o_rs1_data (w_rs1_data),
        .o_rs2_data (w_rs2_data),
        .i_wb_en    (wb_en),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data)
    );

    assign w_opcode  = bus.if_instr[6:0];
    assign w_func3   = bus.if_instr[14:12];
    assign w_func7   = bus.if_instr[31:25];
    assign w_capture = bus.if_valid && bus.if_ready;

    // NOTE: every field gets a default before the case so no path leaves a
    // latch; combinational blocks use blocking '=' throughout.
    always_comb begin
        w_dec    = '0;
        w_dec.rd = bus.if_instr[11:7];
        case (w_opcode)
            OP_R: begin
                w_dec.operand_1 = w_rs1_data;
                w_dec.operand_2 = w_rs2_data;
                w_dec.alu_op    = w_func3;
                w_dec.alu_op2   = w_func7;
            end
            OP_I: begin
                w_dec.operand_1 = w_rs1_data;
                w_dec.operand_2 = imm_i(bus.if_instr);
                w_dec.alu_op    = w_func3;
                // Only shifts carry func7; keeps ADDI from decoding as SUB.
                w_dec.alu_op2   = (w_func3 == 3'b001 || w_func3 == 3'b101) ? w_func7 : F7_BASE;
            end
            OP_LUI: begin
                w_dec.operand_2 = imm_u(bus.if_instr);
            end
            OP_AUIPC: begin
                w_dec.operand_1 = bus.if_pc;
                w_dec.operand_2 = imm_u(bus.if_instr);
            end
            default: begin
                w_dec.illegal = 1'b1;
            end
        endcase
        w_dec.reg_write = !w_dec.illegal && (w_dec.rd != '0);
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update
    // from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ex    <= '0;
            r_pc    <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_ex    <= w_dec;
            r_pc    <= bus.if_pc;
        end else if (bus.ex_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.if_ready     = !r_valid || bus.ex_ready;
    assign bus.ex_valid     = r_valid;
    assign bus.ex_operand_1 = r_ex.operand_1;
    assign bus.ex_operand_2 = r_ex.operand_2;
    assign bus.ex_alu_op    = r_ex.alu_op;
    assign bus.ex_alu_op2   = r_ex.alu_op2;
    assign bus.ex_rd        = r_ex.rd;
    assign bus.ex_reg_write = r_ex.reg_write;
    assign bus.ex_illegal   = r_ex.illegal;
    assign bus.ex_pc        = r_pc;

endmodule

// File: tb/tb_decode_stage.sv
// Directed testbench for decode_stage: hand-computed vectors checked with
// immediate assertions; expectations follow DECODE_WB_BYPASS_EN if defined.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_vec;
    int n_err;

`ifdef DECODE_WB_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h0000_00A5;
`else
    localparam logic [31:0] BYP_EXP = 32'h0000_0005;
`endif

    decode_stage_if bus ();

    decode_stage dut (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .bus     (bus),
        .wb_en   (wb_en),
        .wb_rd   (wb_rd),
        .wb_data (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid = 1'b1;
        bus.if_instr = instr;
        bus.if_pc    = pc;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] data);
        wb_en   = en;
        wb_rd   = rd;
        wb_data = data;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst = 1'b1;
        flush = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        bus.if_valid = 1'b0;
        bus.if_instr = 32'h0;
        bus.if_pc    = 32'h0;
        bus.ex_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_ex_valid",  {31'b0, bus.ex_valid}, 32'h0);
        chk("rst_op1",       bus.ex_operand_1, 32'h0);
        chk("rst_op2",       bus.ex_operand_2, 32'h0);
        chk("rst_rd",        {27'b0, bus.ex_rd}, 32'h0);
        chk("rst_pc",        bus.ex_pc, 32'h0);
        chk("rst_if_ready",  {31'b0, bus.if_ready}, 32'h1);

        // x1 = 5, x2 = 3
        wb(1'b1, 5'd1, 32'd5);
        tick();
        wb(1'b1, 5'd2, 32'd3);
        tick();
        wb(1'b0, 5'd0, 32'h0);

        // SUB x3,x1,x2
        bus.ex_ready = 1'b1;
        issue(32'h402081B3, 32'h0000_0100);
        tick();
        chk("sub_valid",   {31'b0, bus.ex_valid}, 32'h1);
        chk("sub_op1",     bus.ex_operand_1, 32'd5);
        chk("sub_op2",     bus.ex_operand_2, 32'd3);
        chk("sub_aluop",   {29'b0, bus.ex_alu_op}, 32'h0);
        chk("sub_aluop2",  {25'b0, bus.ex_alu_op2}, 32'h20);
        chk("sub_rd",      {27'b0, bus.ex_rd}, 32'd3);
        chk("sub_wr",      {31'b0, bus.ex_reg_write}, 32'h1);
        chk("sub_illegal", {31'b0, bus.ex_illegal}, 32'h0);
        chk("sub_pc",      bus.ex_pc, 32'h0000_0100);

        // ADDI x4,x0,-1
        issue(32'hFFF00213, 32'h0000_0104);
        tick();
        chk("addi_op1",    bus.ex_operand_1, 32'h0);
        chk("addi_op2",    bus.ex_operand_2, 32'hFFFF_FFFF);
        chk("addi_aluop2", {25'b0, bus.ex_alu_op2}, 32'h0);
        chk("addi_rd",     {27'b0, bus.ex_rd}, 32'd4);

        // SRAI x5,x1,2
        issue(32'h4020D293, 32'h0000_0108);
        tick();
        chk("srai_op1",    bus.ex_operand_1, 32'd5);
        chk("srai_op2",    bus.ex_operand_2, 32'h0000_0402);
        chk("srai_aluop",  {29'b0, bus.ex_alu_op}, 32'h5);
        chk("srai_aluop2", {25'b0, bus.ex_alu_op2}, 32'h20);

        // Stall 3 cycles with LUI x7,0x12345 waiting upstream
        bus.ex_ready = 1'b0;
        issue(32'h123453B7, 32'h0000_010C);
        #1;
        chk("stall_if_ready", {31'b0, bus.if_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'b0, bus.ex_valid}, 32'h1);
            chk("stall_rd",    {27'b0, bus.ex_rd}, 32'd5);
            chk("stall_op2",   bus.ex_operand_2, 32'h0000_0402);
            chk("stall_pc",    bus.ex_pc, 32'h0000_0108);
        end
        bus.ex_ready = 1'b1;
        #1;
        chk("unstall_if_ready", {31'b0, bus.if_ready}, 32'h1);
        tick();
        chk("lui_valid", {31'b0, bus.ex_valid}, 32'h1);
        chk("lui_op1",   bus.ex_operand_1, 32'h0);
        chk("lui_op2",   bus.ex_operand_2, 32'h1234_5000);
        chk("lui_rd",    {27'b0, bus.ex_rd}, 32'd7);
        chk("lui_pc",    bus.ex_pc, 32'h0000_010C);
        bus.if_valid = 1'b0;
        tick();
        chk("drain_valid", {31'b0, bus.ex_valid}, 32'h0);

        // AUIPC x8,1
        issue(32'h00001417, 32'h0000_0200);
        tick();
        chk("auipc_op1", bus.ex_operand_1, 32'h0000_0200);
        chk("auipc_op2", bus.ex_operand_2, 32'h0000_1000);
        chk("auipc_wr",  {31'b0, bus.ex_reg_write}, 32'h1);

        // Flush with held entry and incoming ADDI x9,x0,7; writeback to x10 still lands
        bus.ex_ready = 1'b0;
        issue(32'h00700493, 32'h0000_0204);
        flush = 1'b1;
        wb(1'b1, 5'd10, 32'h77);
        tick();
        flush = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        bus.if_valid = 1'b0;
        chk("flush_valid", {31'b0, bus.ex_valid}, 32'h0);
        bus.ex_ready = 1'b1;
        tick();
        chk("flush_dropped", {31'b0, bus.ex_valid}, 32'h0);

        // ADD x11,x10,x0 observes the write made during flush
        issue(32'h000505B3, 32'h0000_0300);
        tick();
        chk("flush_wb_op1", bus.ex_operand_1, 32'h77);

        // Writeback x1=0xA5 concurrent with ADD x6,x1,x0
        wb(1'b1, 5'd1, 32'hA5);
        issue(32'h00008333, 32'h0000_0304);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        chk("bypass_op1", bus.ex_operand_1, BYP_EXP);
        issue(32'h00008333, 32'h0000_0308);
        tick();
        chk("after_wb_op1", bus.ex_operand_1, 32'hA5);

        // Illegal opcode
        issue(32'h0000007F, 32'h0000_030C);
        tick();
        chk("ill_valid",   {31'b0, bus.ex_valid}, 32'h1);
        chk("ill_illegal", {31'b0, bus.ex_illegal}, 32'h1);
        chk("ill_wr",      {31'b0, bus.ex_reg_write}, 32'h0);
        chk("ill_op1",     bus.ex_operand_1, 32'h0);
        chk("ill_op2",     bus.ex_operand_2, 32'h0);

        // Write x0, then ADD x12,x0,x0
        bus.if_valid = 1'b0;
        wb(1'b1, 5'd0, 32'hDEAD);
        tick();
        wb(1'b0, 5'd0, 32'h0);
        issue(32'h00000633, 32'h0000_0310);
        tick();
        chk("x0_op1", bus.ex_operand_1, 32'h0);
        chk("x0_op2", bus.ex_operand_2, 32'h0);
        chk("x0_wr",  {31'b0, bus.ex_reg_write}, 32'h1);

        // ADD x0,x1,x2: legal but rd=0 suppresses reg_write
        issue(32'h00208033, 32'h0000_0314);
        tick();
        chk("rd0_wr",  {31'b0, bus.ex_reg_write}, 32'h0);
        chk("rd0_op2", bus.ex_operand_2, 32'd3);

        // Reset during a stall
        bus.ex_ready = 1'b0;
        issue(32'h002081B3, 32'h0000_0318);
        tick();
        tick();
        chk("pre_rst_valid", {31'b0, bus.ex_valid}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_valid",    {31'b0, bus.ex_valid}, 32'h0);
        chk("midrst_op1",      bus.ex_operand_1, 32'h0);
        chk("midrst_if_ready", {31'b0, bus.if_ready}, 32'h1);

        // Register file cleared by reset: ADD x3,x1,x2 reads zeros
        bus.ex_ready = 1'b1;
        tick();
        chk("post_rst_op1", bus.ex_operand_1, 32'h0);
        chk("post_rst_op2", bus.ex_operand_2, 32'h0);
        bus.if_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the single-issue RV32I integer core, placed directly upstream of the ALU. Accepts fetched instructions over a valid/ready handshake, decodes R-type, I-type ALU, LUI and AUIPC, reads the internal 32x32 register file and registers operands plus func3/func7 into a one-entry pipeline register feeding the ALU. Also owns the register-file write port driven by writeback.

## Interface
- XLEN, 32, datapath width
- REG_COUNT, 32, architectural registers; x0 hardwired to zero
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  kill held entry and the incoming instruction
- if_valid  in  1  fetch offers instruction
- if_ready  out  1  stage accepts this cycle
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- ex_valid  out  1  pipeline register holds a valid entry
- ex_ready  in  1  ALU consumes entry this cycle
- ex_operand_1  out  XLEN  rs1 value, pc (AUIPC) or 0 (LUI)
- ex_operand_2  out  XLEN  rs2 value or immediate
- ex_alu_op  out  3  func3 to ALU
- ex_alu_op2  out  7  func7 to ALU
- ex_rd  out  5  destination register
- ex_reg_write  out  1  entry writes rd
- ex_illegal  out  1  unsupported opcode
- ex_pc  out  32  pc of entry
- wb_en, wb_rd[4:0], wb_data[XLEN-1:0]  in  register-file write port

## Operation
- Opcode 0110011 (R): operand_1=rs1, operand_2=rs2, alu_op=instr[14:12], alu_op2=instr[31:25].
- Opcode 0010011 (I): operand_2=sign-extended instr[31:20]; alu_op2=instr[31:25] only for func3 001/101 (shifts), else 0 (ADDI never decodes as SUB).
- LUI (0110111): operand_1=0, operand_2={instr[31:12],12'b0}, alu_op=000, alu_op2=0. AUIPC (0010111): same with operand_1=if_pc.
- Any other opcode: ex_illegal=1, ex_reg_write=0, operands 0; entry still passes through handshake.
- ex_reg_write=1 for legal entries with rd!=0; rd=0 forces 0.
- Register file: write on wb_en at clock edge; wb_rd=0 ignored; reads of x0 return 0.
- Read without bypass returns pre-write value; upstream hazard logic inserts bubbles. A held (stalled) entry is never refreshed by later writebacks.

## Timing
- if_ready = !ex_valid || ex_ready (combinational, no dependency on if_valid).
- Capture when if_valid && if_ready: pipeline register loads next edge; latency 1 cycle.
- ex_valid next = flush ? 0 : (capture ? 1 : (ex_ready ? 0 : ex_valid)).
- Simultaneous consume and capture: back-to-back, ex_valid stays 1, one instruction per cycle.
- ex_valid && !ex_ready: all ex_* outputs stable.
- flush has priority over capture; incoming instruction dropped, regfile write still performed.
- Reset: ex_valid=0, all ex_* outputs 0, all registers 0; if_ready=1 after reset. Reset mid-stall discards the held entry.

## Configuration
- DECODE_WB_BYPASS_EN defined: read of rs equal to wb_rd with wb_en and rs!=0 returns wb_data in the same cycle.
- Undefined: read returns old register value; wb data visible to reads the cycle after the write.

## Structure
- Shared package core_pkg: opcode constants (OP_R, OP_I, OP_LUI, OP_AUIPC), XLEN, func7 constants F7_BASE/F7_ALT.
- Sub-module regfile (2 read, 1 write, x0 zero, bypass under DECODE_WB_BYPASS_EN); decode logic and pipeline register stay in decode_stage.

## Test plan
- Write x1=5, x2=3; issue SUB x3,x1,x2 (0x402081B3) -> next cycle ex_operand_1=5, ex_operand_2=3, alu_op=000, alu_op2=0100000, rd=3, reg_write=1.
- ADDI x4,x0,-1 (0xFFF00213) -> operand_1=0, operand_2=0xFFFFFFFF, alu_op2=0; SRAI x5,x1,2 (0x4020D293) -> alu_op=101, alu_op2=0100000.
- Hold ex_ready=0 for 3 cycles with if_valid=1 -> if_ready=0, outputs stable; raise ex_ready -> next instruction lands next cycle, no loss or duplication.
- flush with ex_valid=1 and if_valid=1 -> ex_valid=0 next cycle, incoming dropped.
- wb_en=1 wb_rd=1 wb_data=0xA5 same cycle as ADD x6,x1,x0 -> operand_1=0xA5 with DECODE_WB_BYPASS_EN, old x1 without.
- Opcode 0x7F -> ex_illegal=1, reg_write=0; write to x0 then read x0 -> 0; rst mid-stall -> ex_valid=0 next cycle.
